// File: rtl/ff_rd_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : ff_rd_prefetch
// Description : FIFO read-side prefetcher. Pops the pointer manager, absorbs
//               the 1-cycle RAM latency in a 2-entry buffer, drives valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module ff_rd_prefetch #(
    parameter int DATA_W   = 32,
    parameter int FF_DEPTH = 16,
    parameter int FF_PTR_W = $clog2(FF_DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ff_empty,
    input  logic [FF_PTR_W-1:0] ff_rd_ptr,
    output logic                ff_rd_en,
    output logic                ram_rd_en,
    output logic [FF_PTR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0]   ram_rd_data,
    input  logic                flush,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic                out_ready,
    output logic [1:0]          buf_occ
);

    localparam logic [2:0] c_buf_depth = 3'd2;

    logic              r_inflight;
    logic [DATA_W-1:0] r_buf [2];
    logic              r_wr_slot;
    logic              r_rd_slot;
    logic [1:0]        r_occ;

    logic              w_pop;
    logic              w_capture;
    logic              w_issue;
    logic [2:0]        w_credit;
    logic [2:0]        w_occ_next;

    assign w_pop     = out_valid & out_ready;
    assign w_capture = r_inflight & ~flush;

    // Words held plus words still coming back from the RAM, net of this cycle's pop.
    assign w_credit   = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_occ_next = {1'b0, r_occ} + {2'b0, w_capture} - {2'b0, w_pop};

    // rst_n gating keeps the pop request low while reset is held.
    assign w_issue = rst_n & ~ff_empty & ~flush & (w_credit < c_buf_depth);

    assign ff_rd_en    = w_issue;
    assign ram_rd_en   = w_issue;
    assign ram_rd_addr = ff_rd_ptr;

    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_buf[r_rd_slot];
    assign buf_occ   = r_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_wr_slot  <= 1'b0;
            r_rd_slot  <= 1'b0;
            r_occ      <= 2'd0;
        end else begin
            r_inflight <= w_issue;
            if (flush) begin
                r_wr_slot <= 1'b0;
                r_rd_slot <= 1'b0;
                r_occ     <= 2'd0;
            end else begin
                if (w_capture) begin
                    r_wr_slot <= ~r_wr_slot;
                end
                if (w_pop) begin
                    r_rd_slot <= ~r_rd_slot;
                end
                r_occ <= w_occ_next[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
        end else if (w_capture) begin
            r_buf[r_wr_slot] <= ram_rd_data;
        end
    end

    a_occ_max : assert property (@(posedge clk) disable iff (!rst_n)
        flush || (w_occ_next <= c_buf_depth));

endmodule
`default_nettype wire
